// File: rtl/conv_tr_pkg.sv
// Shared state encoding and sizing helpers for the streaming transposed convolution.
package conv_tr_pkg;

  typedef enum logic [1:0] {S_IN, S_MAC, S_DRAIN} state_e;

  function automatic int out_size(input int inSize, input int k, input int stride);
    return (inSize - 1) * stride + k;
  endfunction

  function automatic int acc_width(input int dataW, input int cin, input int k);
    return 2 * dataW + $clog2(cin * k * k) + 1;
  endfunction

endpackage

// File: rtl/conv_tr_mac.sv
// Combinational signed multiply-accumulate, kept separate so it maps cleanly onto a DSP slice.
module conv_tr_mac
  import conv_tr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = acc_width(16, 2, 3)
) (
  input  logic signed [DATA_W-1:0] pixel_i,
  input  logic signed [DATA_W-1:0] weight_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] product;

  assign product = pixel_i * weight_i;
  assign acc_o   = acc_i + ACC_W'(product);

endmodule

// File: rtl/conv_transposed_2d_stream.sv
// Streaming transposed 2D convolution for one output channel: scatter-accumulate each input
// pixel into an OUT x OUT accumulator one tap per cycle, then drain with ready/valid.
module conv_transposed_2d_stream
  import conv_tr_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int IN_SIZE  = 4,
  parameter int K        = 3,
  parameter int STRIDE   = 1,
  parameter int CIN      = 2,
  parameter int OUT_SIZE = out_size(IN_SIZE, K, STRIDE),
  parameter int ACC_W    = acc_width(DATA_W, CIN, K)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [$clog2(CIN*K*K+1)-1:0]     w_addr,
  input  logic signed [DATA_W-1:0]         w_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DATA_W-1:0]         in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [ACC_W-1:0]          out_data,
  output logic                             out_last,
  output logic                             busy
);

  localparam int NTAPS = CIN * K * K;
  localparam int NPIX  = OUT_SIZE * OUT_SIZE;
  localparam int WAW   = $clog2(NTAPS + 1);
  localparam int WIW   = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int AIW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW    = $clog2(CIN + 1);
  localparam int PW    = $clog2(IN_SIZE + 1);
  localparam int KW    = $clog2(K + 1);

  state_e state_q, state_d;

  logic signed [ACC_W-1:0]  acc_q [NPIX];
  logic signed [DATA_W-1:0] weight_q [NTAPS];
  logic signed [DATA_W-1:0] bias_q;
  logic signed [DATA_W-1:0] pixel_q;
  logic [CW-1:0]            cCnt_q, cPix_q;
  logic [PW-1:0]            yCnt_q, xCnt_q, yPix_q, xPix_q;
  logic                     lastPix_q;
  logic [KW-1:0]            ky_q, kx_q;
  logic [AIW-1:0]           drainIdx_q;

  logic [AIW-1:0]           macIdx;
  logic [WIW-1:0]           tapIdx;
  logic signed [ACC_W-1:0]  macSum;
  logic                     frameIdle, inFire, outFire, wFire, lastTap, lastOut;

  assign frameIdle = (cCnt_q == '0) && (yCnt_q == '0) && (xCnt_q == '0);
  assign in_ready  = (state_q == S_IN);
  assign w_ready   = (state_q == S_IN) && frameIdle;
  assign busy      = !frameIdle || (state_q != S_IN);
  assign out_valid = (state_q == S_DRAIN);
  assign lastOut   = (drainIdx_q == AIW'(NPIX - 1));
  assign out_last  = out_valid && lastOut;
  assign out_data  = out_valid ? (acc_q[drainIdx_q] + ACC_W'(bias_q)) : '0;

  assign inFire  = in_valid && in_ready;
  assign outFire = out_valid && out_ready;
  assign wFire   = w_valid && w_ready;
  assign lastTap = (ky_q == KW'(K - 1)) && (kx_q == KW'(K - 1));

  // Target output cell and weight for the current tap of the latched pixel.
  assign macIdx = AIW'((int'(yPix_q) * STRIDE + int'(ky_q)) * OUT_SIZE
                       + int'(xPix_q) * STRIDE + int'(kx_q));
  assign tapIdx = WIW'((int'(cPix_q) * K + int'(ky_q)) * K + int'(kx_q));

  conv_tr_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) uMac (
    .pixel_i  (pixel_q),
    .weight_i (weight_q[tapIdx]),
    .acc_i    (acc_q[macIdx]),
    .acc_o    (macSum)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IN:    if (in_valid) state_d = S_MAC;
      S_MAC:   if (lastTap) state_d = lastPix_q ? S_DRAIN : S_IN;
      S_DRAIN: if (out_ready && lastOut) state_d = S_IN;
      default: state_d = S_IN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPIX; i++) acc_q[i] <= '0;
      for (int i = 0; i < NTAPS; i++) weight_q[i] <= '0;
      bias_q     <= '0;
      pixel_q    <= '0;
      cCnt_q     <= '0;
      yCnt_q     <= '0;
      xCnt_q     <= '0;
      cPix_q     <= '0;
      yPix_q     <= '0;
      xPix_q     <= '0;
      lastPix_q  <= 1'b0;
      ky_q       <= '0;
      kx_q       <= '0;
      drainIdx_q <= '0;
    end else begin
      if (wFire) begin
        if (w_addr < WAW'(NTAPS))       weight_q[w_addr[WIW-1:0]] <= w_data;
        else if (w_addr == WAW'(NTAPS)) bias_q <= w_data;
      end

      // Counters always point at the next pixel expected; they wrap to zero after the frame.
      if (inFire) begin
        pixel_q   <= in_data;
        cPix_q    <= cCnt_q;
        yPix_q    <= yCnt_q;
        xPix_q    <= xCnt_q;
        lastPix_q <= (cCnt_q == CW'(CIN - 1)) && (yCnt_q == PW'(IN_SIZE - 1))
                     && (xCnt_q == PW'(IN_SIZE - 1));
        if (xCnt_q == PW'(IN_SIZE - 1)) begin
          xCnt_q <= '0;
          if (yCnt_q == PW'(IN_SIZE - 1)) begin
            yCnt_q <= '0;
            cCnt_q <= (cCnt_q == CW'(CIN - 1)) ? '0 : cCnt_q + CW'(1);
          end else begin
            yCnt_q <= yCnt_q + PW'(1);
          end
        end else begin
          xCnt_q <= xCnt_q + PW'(1);
        end
      end

      if (state_q == S_MAC) begin
        acc_q[macIdx] <= macSum;
        if (kx_q == KW'(K - 1)) begin
          kx_q <= '0;
          ky_q <= lastTap ? '0 : ky_q + KW'(1);
        end else begin
          kx_q <= kx_q + KW'(1);
        end
      end

      // Draining also clears each cell so the next frame starts from zero.
      if (outFire) begin
        acc_q[drainIdx_q] <= '0;
        drainIdx_q        <= lastOut ? '0 : drainIdx_q + AIW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_transposed_2d_stream.sv
// Bench for conv_transposed_2d_stream: three configurations share one stimulus path,
// a gather-form reference model supplies expected frames and a negedge process compares.
module tb_conv_transposed_2d_stream;

  typedef longint lq_t[$];

  // Configurations: 0 = CIN2/IN2/K2/S1, 1 = CIN1/IN2/K2/S2, 2 = default CIN2/IN4/K3/S1
  int cfgCin [3] = '{2, 1, 2};
  int cfgIn  [3] = '{2, 2, 4};
  int cfgK   [3] = '{2, 2, 3};
  int cfgS   [3] = '{1, 2, 1};

  logic clk;
  logic rst;
  int   sel;
  logic wValid;
  logic [4:0] wAddr;
  logic signed [15:0] wData;
  logic inValid;
  logic signed [15:0] inData;
  logic outReady;

  logic wReadyA, inReadyA, validA, lastA, busyA;
  logic wReadyB, inReadyB, validB, lastB, busyB;
  logic wReadyC, inReadyC, validC, lastC, busyC;
  logic signed [35:0] dataA;
  logic signed [34:0] dataB;
  logic signed [37:0] dataC;

  logic   wReadySel, inReadySel, validSel, lastSel, busySel;
  longint dataSel;

  int   nCompared = 0;
  int   nFailed   = 0;
  int   cyc       = 0;
  int   firstValidCyc;
  int   lastAcceptCyc;
  int   acceptCycs[$];
  lq_t  expQ;
  lq_t  gotQ;
  logic bpMode = 1'b0;
  logic [3:0] bpPat = 4'b1001;
  int   bpPos = 0;

  conv_transposed_2d_stream #(.DATA_W(16), .IN_SIZE(2), .K(2), .STRIDE(1), .CIN(2)) dutA (
    .clk(clk), .rst(rst),
    .w_valid(wValid && sel == 0), .w_ready(wReadyA), .w_addr(wAddr[3:0]), .w_data(wData),
    .in_valid(inValid && sel == 0), .in_ready(inReadyA), .in_data(inData),
    .out_valid(validA), .out_ready(outReady), .out_data(dataA), .out_last(lastA), .busy(busyA)
  );

  conv_transposed_2d_stream #(.DATA_W(16), .IN_SIZE(2), .K(2), .STRIDE(2), .CIN(1)) dutB (
    .clk(clk), .rst(rst),
    .w_valid(wValid && sel == 1), .w_ready(wReadyB), .w_addr(wAddr[2:0]), .w_data(wData),
    .in_valid(inValid && sel == 1), .in_ready(inReadyB), .in_data(inData),
    .out_valid(validB), .out_ready(outReady), .out_data(dataB), .out_last(lastB), .busy(busyB)
  );

  conv_transposed_2d_stream dutC (
    .clk(clk), .rst(rst),
    .w_valid(wValid && sel == 2), .w_ready(wReadyC), .w_addr(wAddr), .w_data(wData),
    .in_valid(inValid && sel == 2), .in_ready(inReadyC), .in_data(inData),
    .out_valid(validC), .out_ready(outReady), .out_data(dataC), .out_last(lastC), .busy(busyC)
  );

  always_comb begin
    wReadySel = wReadyA; inReadySel = inReadyA; validSel = validA;
    lastSel = lastA; busySel = busyA; dataSel = 64'(dataA);
    if (sel == 1) begin
      wReadySel = wReadyB; inReadySel = inReadyB; validSel = validB;
      lastSel = lastB; busySel = busyB; dataSel = 64'(dataB);
    end else if (sel == 2) begin
      wReadySel = wReadyC; inReadySel = inReadyC; validSel = validC;
      lastSel = lastC; busySel = busyC; dataSel = 64'(dataC);
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Back-pressure source: either always ready or the repeating pattern 1,0,0,1.
  initial begin
    outReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bpMode) begin
        outReady = bpPat[bpPos % 4];
        bpPos++;
      end else begin
        outReady = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkFrame(input string name, input lq_t act, input lq_t exp);
    checkOutput({name, " length"}, act.size(), exp.size());
    for (int i = 0; i < act.size() && i < exp.size(); i++)
      checkOutput($sformatf("%s[%0d]", name, i), act[i], exp[i]);
  endtask

  // Gather form: each output cell sums every (pixel, tap) pair that lands on it.
  function automatic lq_t model(input int s, input lq_t pix, input lq_t wts, input longint bias);
    lq_t res;
    int cin = cfgCin[s];
    int n   = cfgIn[s];
    int k   = cfgK[s];
    int st  = cfgS[s];
    int o   = (n - 1) * st + k;
    for (int oy = 0; oy < o; oy++)
      for (int ox = 0; ox < o; ox++) begin
        longint sum = bias;
        for (int c = 0; c < cin; c++)
          for (int iy = 0; iy < n; iy++)
            for (int ix = 0; ix < n; ix++) begin
              int ky = oy - iy * st;
              int kx = ox - ix * st;
              if (ky >= 0 && ky < k && kx >= 0 && kx < k)
                sum += pix[(c * n + iy) * n + ix] * wts[(c * k + ky) * k + kx];
            end
        res.push_back(sum);
      end
    return res;
  endfunction

  // Compare process: every cycle the selected DUT presents data, check it against the model.
  always @(negedge clk) begin
    if (validSel) begin
      if (firstValidCyc < 0) firstValidCyc = cyc;
      if (expQ.size() == 0) begin
        checkOutput("spurious out_valid", 1, 0);
      end else begin
        checkOutput("out_data", dataSel, expQ[0]);
        checkOutput("out_last", longint'(lastSel), longint'(expQ.size() == 1));
        if (outReady) begin
          gotQ.push_back(dataSel);
          expQ.delete(0);
        end
      end
    end
  end

  task automatic writeWeight(input int addr, input longint data);
    logic accepted = 1'b0;
    wValid = 1'b1;
    wAddr  = 5'(addr);
    wData  = 16'(data);
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clk);
      accepted = wReadySel;
      @(posedge clk);
      #1;
    end
    wValid = 1'b0;
    if (!accepted) checkOutput("weight write timeout", 0, 1);
  endtask

  task automatic loadWeights(input lq_t wts, input longint bias);
    for (int i = 0; i < wts.size(); i++) writeWeight(i, wts[i]);
    writeWeight(wts.size(), bias);
  endtask

  task automatic sendPixel(input longint p);
    logic accepted = 1'b0;
    inValid = 1'b1;
    inData  = 16'(p);
    for (int t = 0; t < 100 && !accepted; t++) begin
      @(negedge clk);
      accepted = inReadySel;
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    if (!accepted) checkOutput("input accept timeout", 0, 1);
    lastAcceptCyc = cyc;
    acceptCycs.push_back(cyc);
  endtask

  task automatic applyStimulus(input lq_t pix);
    for (int i = 0; i < pix.size(); i++) sendPixel(pix[i]);
  endtask

  task automatic waitDrain();
    logic done = 1'b0;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clk);
      #1;
      done = (expQ.size() == 0) && !validSel;
    end
    if (!done) checkOutput("drain timeout", expQ.size(), 0);
  endtask

  task automatic startFrame(input lq_t expected);
    expQ = expected;
    gotQ.delete();
    acceptCycs.delete();
    firstValidCyc = -1;
  endtask

  lq_t ones8, ones4, wA1, wA2, wB, pixB, wC, pixC, golden, litA1, litA2, litB;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; sel = 0; wValid = 1'b0; wAddr = '0; wData = '0;
    inValid = 1'b0; inData = '0; firstValidCyc = -1; lastAcceptCyc = 0;

    ones8 = '{1, 1, 1, 1, 1, 1, 1, 1};
    ones4 = '{1, 1, 1, 1};
    wA1   = '{1, 1, 1, 1, 0, 0, 0, 0};
    wA2   = '{1, 1, 1, 1, -2, -2, -2, -2};
    wB    = '{1, 1, 1, 1};
    pixB  = '{1, 2, 3, 4};
    litA1 = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    litA2 = '{4, 3, 4, 3, 1, 3, 4, 3, 4};
    litB  = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
    for (int i = 0; i < 18; i++) wC.push_back(-32768);
    for (int i = 0; i < 32; i++) pixC.push_back(-32768);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", inReadySel, 1);
    checkOutput("reset w_ready", wReadySel, 1);
    checkOutput("reset out_valid", validSel, 0);
    checkOutput("reset out_last", lastSel, 0);
    checkOutput("reset busy", busySel, 0);
    checkOutput("reset out_data", dataSel, 0);
    @(posedge clk); #1;

    // Channel 1 weighted zero reproduces the single-channel all-ones case.
    $display("[TB] frame A1: all-ones, single effective channel");
    loadWeights(wA1, 0);
    golden = model(0, ones8, wA1, 0);
    checkFrame("model A1", golden, litA1);
    startFrame(golden);
    applyStimulus(ones8);
    waitDrain();
    checkFrame("A1 output", gotQ, litA1);
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("A1 pixel spacing %0d", i), acceptCycs[i] - acceptCycs[i-1], 5);
    checkOutput("A1 first valid latency", firstValidCyc - lastAcceptCyc, 4);

    $display("[TB] frame A2: two channels, bias 5, back-pressure");
    loadWeights(wA2, 5);
    golden = model(0, ones8, wA2, 5);
    checkFrame("model A2", golden, litA2);
    bpMode = 1'b1;
    startFrame(golden);
    applyStimulus(ones8);
    waitDrain();
    bpMode = 1'b0;
    checkFrame("A2 backpressure output", gotQ, litA2);

    $display("[TB] frame A3: repeat frame, weight write attempted during MAC");
    startFrame(golden);
    sendPixel(1);
    wValid = 1'b1; wAddr = 5'd0; wData = 16'sd99;
    @(negedge clk);
    checkOutput("w_ready during MAC", wReadySel, 0);
    checkOutput("busy during MAC", busySel, 1);
    checkOutput("in_ready during MAC", inReadySel, 0);
    @(posedge clk); #1 wValid = 1'b0;
    for (int i = 1; i < 8; i++) sendPixel(1);
    waitDrain();
    checkFrame("A3 repeat output", gotQ, litA2);

    $display("[TB] frame A4: reset during MAC of third pixel");
    startFrame('{});
    for (int i = 0; i < 3; i++) sendPixel(1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid-MAC reset in_ready", inReadySel, 1);
    checkOutput("mid-MAC reset busy", busySel, 0);
    checkOutput("mid-MAC reset out_valid", validSel, 0);
    checkOutput("mid-MAC reset w_ready", wReadySel, 1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    loadWeights(wA2, 5);
    startFrame(golden);
    applyStimulus(ones8);
    waitDrain();
    checkFrame("A4 post-reset output", gotQ, litA2);

    $display("[TB] frame B: stride 2, no overlap");
    sel = 1;
    loadWeights(wB, 0);
    golden = model(1, pixB, wB, 0);
    checkFrame("model B", golden, litB);
    startFrame(golden);
    applyStimulus(pixB);
    waitDrain();
    checkFrame("B output", gotQ, litB);

    $display("[TB] frame C: extreme values, CIN=2, K=3");
    sel = 2;
    loadWeights(wC, -32768);
    golden = model(2, pixC, wC, -32768);
    checkOutput("model C corner", golden[0], 64'sd2147450880);
    checkOutput("model C centre", golden[14], 64'sd19327320064);
    startFrame(golden);
    applyStimulus(pixC);
    waitDrain();
    checkOutput("C output count", gotQ.size(), 36);
    if (gotQ.size() == 36) begin
      checkOutput("C corner", gotQ[0], 64'sd2147450880);
      checkOutput("C centre", gotQ[14], 64'sd19327320064);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
